top_level: RTL and testbench



---
 rtl/top_level.sv | 203 ++++++++++++++++++++
 tb/tb_top_level.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/top_level.sv
// 16-bit multicycle processor core: program counter, unified 256-word memory,
// 8-entry register file, ALU and the control FSM that sequences them.
module top_level (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] in,
  output logic [15:0] out
);

  typedef enum logic [4:0] {
    S_FETCH    = 5'd0,
    S_DECODE   = 5'd1,
    S_MEMADDR  = 5'd2,
    S_MEMREAD  = 5'd3,
    S_MEMWB    = 5'd4,
    S_MEMWRITE = 5'd5,
    S_REXEC    = 5'd6,
    S_RWB      = 5'd7,
    S_IEXEC    = 5'd8,
    S_IWB      = 5'd9,
    S_BRANCH   = 5'd10,
    S_JUMP     = 5'd11,
    S_JAL      = 5'd12,
    S_JR       = 5'd13,
    S_IN       = 5'd14,
    S_OUT      = 5'd15
  } state_t;

  state_t      state_reg, state_next;
  logic [15:0] pc_reg, pc_next;
  logic [15:0] ir_reg, ir_next;
  logic [15:0] a_reg, a_next;
  logic [15:0] b_reg, b_next;
  logic [15:0] alu_out_reg, alu_out_next;
  logic [15:0] mdr_reg, mdr_next;
  logic [15:0] out_reg, out_next;

  logic [15:0] regs [8];
  logic        reg_we;
  logic [2:0]  reg_waddr;
  logic [15:0] reg_wdata;
  logic        mem_we;

  // Program image, loaded at elaboration; reset never touches memory.
  logic [15:0] mem [256] = '{
    0: 16'h1105,  1: 16'h117D,  2: 16'h0970,  3: 16'h9C00,
    4: 16'hA000,  5: 16'h7020,  6: 16'h9600,  7: 16'h8040,
    8: 16'h9200,  9: 16'h1145, 10: 16'h4942, 11: 16'h9800,
   12: 16'h9800, 13: 16'h5942, 14: 16'h1007, 15: 16'h9000,
   16: 16'h9A00, 17: 16'h6040, 32: 16'h0607,
   64: 16'h1112, 65: 16'h11C8, 66: 16'h09E5, 67: 16'h119A,
   68: 16'h0DB0, 69: 16'h09A3, 70: 16'h353F, 71: 16'h21FE,
   72: 16'h9E00, 73: 16'h0989, 74: 16'h9200, 75: 16'h094A,
   76: 16'h9200, 77: 16'h11BF, 78: 16'h0D4C, 79: 16'h9200,
   80: 16'h0DCE, 81: 16'h9200, 82: 16'h0B8C, 83: 16'h9200,
   84: 16'h6054,
   default: 16'h0000
  };

  logic [3:0]  op;
  logic [2:0]  rs, rt, rd, funct;
  logic [15:0] simm;

  assign op    = ir_reg[15:12];
  assign rs    = ir_reg[11:9];
  assign rt    = ir_reg[8:6];
  assign rd    = ir_reg[5:3];
  assign funct = ir_reg[2:0];
  assign simm  = {{10{ir_reg[5]}}, ir_reg[5:0]};
  assign out   = out_reg;

  function automatic logic [15:0] alu_r(input logic [2:0] f, input logic [15:0] x, input logic [15:0] y);
    case (f)
      3'd0:    return x + y;
      3'd1:    return x - y;
      3'd2:    return x & y;
      3'd3:    return x | y;
      3'd4:    return {15'd0, $signed(x) < $signed(y)};
      3'd5:    return x << y[3:0];
      3'd6:    return x >> y[3:0];
      default: return x;
    endcase
  endfunction

  always_comb begin
    state_next   = S_FETCH;
    pc_next      = pc_reg;
    ir_next      = ir_reg;
    a_next       = a_reg;
    b_next       = b_reg;
    alu_out_next = alu_out_reg;
    mdr_next     = mdr_reg;
    out_next     = out_reg;
    reg_we       = 1'b0;
    reg_waddr    = rt;
    reg_wdata    = alu_out_reg;
    mem_we       = 1'b0;

    case (state_reg)
      S_FETCH: begin
        ir_next    = mem[pc_reg[7:0]];
        pc_next    = pc_reg + 16'd1;
        state_next = S_DECODE;
      end
      S_DECODE: begin
        a_next       = regs[rs];
        b_next       = regs[rt];
        alu_out_next = pc_reg + simm;
        case (op)
          4'h0:       state_next = (funct == 3'd7) ? S_JR : S_REXEC;
          4'h1:       state_next = S_IEXEC;
          4'h2, 4'h3: state_next = S_MEMADDR;
          4'h4, 4'h5: state_next = S_BRANCH;
          4'h6:       state_next = S_JUMP;
          4'h7:       state_next = S_JAL;
          4'h8:       state_next = S_IN;
          4'h9:       state_next = S_OUT;
          default:    state_next = S_FETCH;
        endcase
      end
      S_MEMADDR: begin
        alu_out_next = a_reg + simm;
        state_next   = (op == 4'h2) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        mdr_next   = mem[alu_out_reg[7:0]];
        state_next = S_MEMWB;
      end
      S_MEMWB: begin
        reg_we    = 1'b1;
        reg_wdata = mdr_reg;
      end
      S_MEMWRITE: mem_we = 1'b1;
      S_REXEC: begin
        alu_out_next = alu_r(funct, a_reg, b_reg);
        state_next   = S_RWB;
      end
      S_RWB: begin
        reg_we    = 1'b1;
        reg_waddr = rd;
      end
      S_IEXEC: begin
        alu_out_next = a_reg + simm;
        state_next   = S_IWB;
      end
      S_IWB: reg_we = 1'b1;
      // beq takes the branch on equality, bne on inequality.
      S_BRANCH: if ((a_reg == b_reg) == (op == 4'h4)) pc_next = alu_out_reg;
      S_JUMP:   pc_next = {pc_reg[15:12], ir_reg[11:0]};
      S_JAL: begin
        pc_next   = {pc_reg[15:12], ir_reg[11:0]};
        reg_we    = 1'b1;
        reg_waddr = 3'd3;
        reg_wdata = pc_reg;
      end
      S_JR: pc_next = a_reg;
      S_IN: begin
        reg_we    = 1'b1;
        reg_wdata = in;
      end
      S_OUT:   out_next = a_reg;
      default: state_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg   <= S_FETCH;
      pc_reg      <= 16'h0000;
      ir_reg      <= 16'h0000;
      a_reg       <= 16'h0000;
      b_reg       <= 16'h0000;
      alu_out_reg <= 16'h0000;
      mdr_reg     <= 16'h0000;
      out_reg     <= 16'h0000;
    end else begin
      state_reg   <= state_next;
      pc_reg      <= pc_next;
      ir_reg      <= ir_next;
      a_reg       <= a_next;
      b_reg       <= b_next;
      alu_out_reg <= alu_out_next;
      mdr_reg     <= mdr_next;
      out_reg     <= out_next;
    end
  end

  // r0 is never written, so it keeps reading zero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      regs <= '{16'h0000, 16'h0000, 16'h00FF, 16'h0000,
                16'h0000, 16'h0000, 16'h0000, 16'h0000};
    end else if (reg_we && reg_waddr != 3'd0) begin
      regs[reg_waddr] <= reg_wdata;
    end
  end

  // Write enable comes from the state register, so an async reset cancels it.
  always_ff @(posedge clock) begin
    if (mem_we) mem[alu_out_reg[7:0]] <= b_reg;
  end

endmodule

// File: tb/tb_top_level.sv
// Bench for top_level: an instruction-level interpreter of the same program
// image predicts the output port cycle by cycle; literals pin key events.
module tb_top_level;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] in_port = 16'hBEEF;
  logic [15:0] out_port;

  int checks = 0;
  int errors = 0;
  int tb_cyc = 0;

  top_level dut (
    .clock (clock),
    .reset (reset),
    .in    (in_port),
    .out   (out_port)
  );

  always #5 clock = ~clock;

  // Reference model state
  logic [15:0] img    [256];
  logic [15:0] m_mem  [256];
  logic [15:0] m_regs [8];
  logic [15:0] m_pc;
  logic [15:0] m_out;
  int          m_left;
  int          m_cycle;
  logic [15:0] log_val [$];
  int          log_cyc [$];

  // Hand-computed output events (cycle after reset release, value)
  int          lit_cyc [11] = '{15, 26, 32, 49, 52, 91, 98, 105, 116, 123, 130};
  logic [15:0] lit_val [11] = '{16'h0002, 16'h0006, 16'hBEEF, 16'h0000, 16'h0005,
                                16'h1234, 16'h1200, 16'h0004, 16'h0001, 16'h0FFF, 16'h0000};

  function automatic logic [15:0] asm_i(input logic [3:0] op, input int rs, input int rt, input int imm);
    return {op, 3'(rs), 3'(rt), 6'(imm)};
  endfunction

  function automatic logic [15:0] asm_r(input int rs, input int rt, input int rd, input int f);
    return {4'h0, 3'(rs), 3'(rt), 3'(rd), 3'(f)};
  endfunction

  function automatic logic [15:0] asm_j(input logic [3:0] op, input int target);
    return {op, 12'(target)};
  endfunction

  function automatic int cycles_of(input logic [15:0] w);
    case (w[15:12])
      4'h0:                               return (w[2:0] == 3'd7) ? 3 : 4;
      4'h1, 4'h3:                         return 4;
      4'h2:                               return 5;
      4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9: return 3;
      default:                            return 2;
    endcase
  endfunction

  task automatic model_reset();
    m_pc = 16'h0000;
    for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;
    m_regs[2] = 16'h00FF;
    m_out   = 16'h0000;
    m_cycle = 0;
    m_left  = cycles_of(m_mem[0]);
    log_val.delete();
    log_cyc.delete();
  endtask

  task automatic model_wr(input logic [2:0] r, input logic [15:0] v);
    if (r != 3'd0) m_regs[r] = v;
  endtask

  // Applies one whole instruction's architectural effect.
  task automatic model_exec();
    logic [15:0] w, simm, pcn, x, y, res, npc, ea;
    w    = m_mem[m_pc[7:0]];
    simm = {{10{w[5]}}, w[5:0]};
    pcn  = m_pc + 16'd1;
    x    = m_regs[w[11:9]];
    y    = m_regs[w[8:6]];
    npc  = pcn;
    ea   = x + simm;
    res  = 16'h0000;
    case (w[15:12])
      4'h0: begin
        case (w[2:0])
          3'd0: res = x + y;
          3'd1: res = x - y;
          3'd2: res = x & y;
          3'd3: res = x | y;
          3'd4: res = ($signed(x) < $signed(y)) ? 16'd1 : 16'd0;
          3'd5: res = x << y[3:0];
          3'd6: res = x >> y[3:0];
          default: npc = x;
        endcase
        if (w[2:0] != 3'd7) model_wr(w[5:3], res);
      end
      4'h1: model_wr(w[8:6], ea);
      4'h2: model_wr(w[8:6], m_mem[ea[7:0]]);
      4'h3: m_mem[ea[7:0]] = y;
      4'h4: if (x == y) npc = pcn + simm;
      4'h5: if (x != y) npc = pcn + simm;
      4'h6: npc = {pcn[15:12], w[11:0]};
      4'h7: begin
        model_wr(3'd3, pcn);
        npc = {pcn[15:12], w[11:0]};
      end
      4'h8: model_wr(w[8:6], in_port);
      4'h9: begin
        m_out = x;
        log_val.push_back(x);
        log_cyc.push_back(m_cycle);
      end
      default: ;
    endcase
    m_pc = npc;
  endtask

  initial forever begin
    @(posedge clock or posedge reset);
    if (reset) begin
      model_reset();
    end else begin
      m_cycle++;
      m_left--;
      if (m_left == 0) begin
        model_exec();
        m_left = cycles_of(m_mem[m_pc[7:0]]);
      end
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clock);
      tb_cyc++;
      checks++;
      if (out_port !== m_out) begin
        errors++;
        if (errors < 20) $display("FAIL out_track cycle %0d: got %h, expected %h", tb_cyc, out_port, m_out);
      end
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_pc"}, dut.pc_reg, 16'h0000);
    check({tag, "_state"}, 16'(dut.state_reg), 16'h0000);
    check({tag, "_out"}, out_port, 16'h0000);
    for (int r = 0; r < 8; r++)
      check($sformatf("%s_r%0d", tag, r), dut.regs[r], (r == 2) ? 16'h00FF : 16'h0000);
  endtask

  task automatic check_log(input int n);
    checks++;
    if (log_val.size() != n) begin
      errors++;
      $display("FAIL log_count: got %0d, expected %0d", log_val.size(), n);
    end
    for (int i = 0; i < n && i < log_val.size(); i++) begin
      check($sformatf("log_val%0d", i), log_val[i], lit_val[i]);
      check($sformatf("log_cyc%0d", i), 16'(log_cyc[i]), 16'(lit_cyc[i]));
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) img[i] = 16'h0000;
    img[0]  = asm_i(4'h1, 0, 4, 5);     // addi r4,r0,5
    img[1]  = asm_i(4'h1, 0, 5, -3);    // addi r5,r0,-3
    img[2]  = asm_r(4, 5, 6, 0);        // add r6,r4,r5
    img[3]  = asm_i(4'h9, 6, 0, 0);     // out r6
    img[4]  = asm_j(4'hA, 0);           // undefined op
    img[5]  = asm_j(4'h7, 'h020);       // jal 0x020
    img[6]  = asm_i(4'h9, 3, 0, 0);     // out r3
    img[7]  = asm_i(4'h8, 0, 1, 0);     // in r1
    img[8]  = asm_i(4'h9, 1, 0, 0);     // out r1
    img[9]  = asm_i(4'h1, 0, 5, 5);     // addi r5,r0,5
    img[10] = asm_i(4'h4, 4, 5, 2);     // beq r4,r5,+2
    img[11] = asm_i(4'h9, 4, 0, 0);     // out r4 (skipped)
    img[12] = asm_i(4'h9, 4, 0, 0);     // out r4 (skipped)
    img[13] = asm_i(4'h5, 4, 5, 2);     // bne r4,r5,+2
    img[14] = asm_i(4'h1, 0, 0, 7);     // addi r0,r0,7
    img[15] = asm_i(4'h9, 0, 0, 0);     // out r0
    img[16] = asm_i(4'h9, 5, 0, 0);     // out r5
    img[17] = asm_j(4'h6, 'h040);       // j 0x040
    img[32] = asm_r(3, 0, 0, 7);        // jr r3
    img[64] = asm_i(4'h1, 0, 4, 18);    // addi r4,r0,18
    img[65] = asm_i(4'h1, 0, 7, 8);     // addi r7,r0,8
    img[66] = asm_r(4, 7, 4, 5);        // sll r4,r4,r7
    img[67] = asm_i(4'h1, 0, 6, 26);    // addi r6,r0,26
    img[68] = asm_r(6, 6, 6, 0);        // add r6,r6,r6
    img[69] = asm_r(4, 6, 4, 3);        // or r4,r4,r6
    img[70] = asm_i(4'h3, 2, 4, -1);    // sw r4,-1(r2)
    img[71] = asm_i(4'h2, 0, 7, -2);    // lw r7,-2(r0)
    img[72] = asm_i(4'h9, 7, 0, 0);     // out r7
    img[73] = asm_r(4, 6, 1, 1);        // sub r1,r4,r6
    img[74] = asm_i(4'h9, 1, 0, 0);
    img[75] = asm_r(4, 5, 1, 2);        // and r1,r4,r5
    img[76] = asm_i(4'h9, 1, 0, 0);
    img[77] = asm_i(4'h1, 0, 6, -1);    // addi r6,r0,-1
    img[78] = asm_r(6, 5, 1, 4);        // slt r1,r6,r5
    img[79] = asm_i(4'h9, 1, 0, 0);
    img[80] = asm_r(6, 7, 1, 6);        // srl r1,r6,r7
    img[81] = asm_i(4'h9, 1, 0, 0);
    img[82] = asm_r(5, 6, 1, 4);        // slt r1,r5,r6
    img[83] = asm_i(4'h9, 1, 0, 0);
    img[84] = asm_j(4'h6, 'h054);       // j 0x054 (halt loop)
    for (int i = 0; i < 256; i++) m_mem[i] = img[i];
    model_reset();

    repeat (2) @(negedge clock);
    check_reset("por");
    reset = 1'b0;

    step(1);
    check("fetch_ir", dut.ir_reg, 16'h1105);
    check("fetch_pc", dut.pc_reg, 16'h0001);
    step(13);
    check("out_before_first", out_port, 16'h0000);
    step(1);
    check("out_first", out_port, 16'h0002);
    step(5);
    check("jal_pc", dut.pc_reg, 16'h0020);
    check("jal_ra", dut.regs[3], 16'h0006);
    step(3);
    check("jr_pc", dut.pc_reg, 16'h0006);
    step(6);
    check("in_r1", dut.regs[1], 16'hBEEF);
    step(10);
    check("beq_pc", dut.pc_reg, 16'd13);
    step(3);
    check("bne_pc", dut.pc_reg, 16'd14);
    step(4);
    check("r0_zero", dut.regs[0], 16'h0000);
    step(36);
    check("sw_in_memwrite", 16'(dut.state_reg), 16'd5);
    check_log(5);

    // Reset lands on the sw's write state: the store must be dropped.
    reset = 1'b1;
    #1;
    check_reset("mid");
    check("sw_suppressed", dut.mem[254], 16'h0000);
    @(negedge clock);
    @(negedge clock);
    reset  = 1'b0;
    tb_cyc = 0;

    step(140);
    check_log(11);
    check("mem_fe", dut.mem[254], 16'h1234);
    check("r7_lw", dut.regs[7], 16'h1234);
    check("r1_slt", dut.regs[1], 16'h0000);
    check("r6_neg", dut.regs[6], 16'hFFFF);
    for (int r = 0; r < 8; r++)
      check($sformatf("final_r%0d", r), dut.regs[r], m_regs[r]);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
